// File: rtl/mem_arbiter.sv
// Serialises datapath instruction-fetch and data requests onto one single-port RAM.
// Data requests win; a sticky watchdog flags RAM accesses that never complete.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic [DATA_W-1:0] imemload,
  output logic              ihit,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] dmemload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

  state_t      state, state_next;
  logic [15:0] wait_cnt;
  logic        dreq;

  assign dreq = dmemREN | dmemWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counter is held at zero in IDLE, so every new grant starts counting from 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (!ram_ready && wait_cnt != 16'hFFFF) begin
      wait_cnt <= wait_cnt + 16'd1;
      if (wait_cnt + 16'd1 >= TIMEOUT_V) begin
        timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    ihit       = 1'b0;
    dhit       = 1'b0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    imemload   = '0;
    dmemload   = '0;
    case (state)
      IDLE: begin
        if (dreq) begin
          state_next = DACC;
        end else if (imemREN) begin
          state_next = IACC;
        end
      end
      DACC: begin
        ramaddr  = dmemaddr;
        ramstore = dmemstore;
        ramWEN   = dmemWEN;
        ramREN   = dmemREN & ~dmemWEN;
        // A dropped request (flush) abandons the access without a hit.
        if (!dreq) begin
          state_next = IDLE;
        end else if (ram_ready) begin
          dhit       = 1'b1;
          dmemload   = ramload;
          state_next = IDLE;
        end
      end
      IACC: begin
        ramaddr = imemaddr;
        ramREN  = imemREN;
        if (!imemREN) begin
          state_next = IDLE;
        end else if (ram_ready) begin
          ihit       = 1'b1;
          imemload   = ramload;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for mem_arbiter
// (watchdog built with TIMEOUT=4).
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] dmemload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] rload;
    logic        rdy;
    logic        e_ihit;
    logic        e_dhit;
    logic        e_rren;
    logic        e_rwen;
    logic [31:0] e_raddr;
    logic [31:0] e_rstore;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic iren, logic [31:0] iaddr, logic dren, logic dwen, logic [31:0] daddr,
    logic [31:0] dstore, logic [31:0] rload, logic rdy,
    logic e_ihit, logic e_dhit, logic e_rren, logic e_rwen, logic [31:0] e_raddr,
    logic [31:0] e_rstore, logic [31:0] e_iload, logic [31:0] e_dload);
    vec_t v;
    v.iren = iren;     v.iaddr = iaddr;   v.dren = dren;     v.dwen = dwen;
    v.daddr = daddr;   v.dstore = dstore; v.rload = rload;   v.rdy = rdy;
    v.e_ihit = e_ihit; v.e_dhit = e_dhit; v.e_rren = e_rren; v.e_rwen = e_rwen;
    v.e_raddr = e_raddr; v.e_rstore = e_rstore; v.e_iload = e_iload; v.e_dload = e_dload;
    return v;
  endfunction

  task automatic check_sig(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    imemREN   = v.iren;
    imemaddr  = v.iaddr;
    dmemREN   = v.dren;
    dmemWEN   = v.dwen;
    dmemaddr  = v.daddr;
    dmemstore = v.dstore;
    ramload   = v.rload;
    ram_ready = v.rdy;
  endtask

  task automatic check_output(input string tag, input vec_t v);
    check_sig({tag, " ihit"}, 32'(ihit), 32'(v.e_ihit));
    check_sig({tag, " dhit"}, 32'(dhit), 32'(v.e_dhit));
    check_sig({tag, " ramREN"}, 32'(ramREN), 32'(v.e_rren));
    check_sig({tag, " ramWEN"}, 32'(ramWEN), 32'(v.e_rwen));
    check_sig({tag, " ramaddr"}, ramaddr, v.e_raddr);
    check_sig({tag, " ramstore"}, ramstore, v.e_rstore);
    check_sig({tag, " imemload"}, imemload, v.e_iload);
    check_sig({tag, " dmemload"}, dmemload, v.e_dload);
    check_sig({tag, " hit_overlap"}, 32'(ihit & dhit), 32'd0);
    check_sig({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    // Each row: inputs for one cycle, then outputs expected in that cycle.
    vecs.push_back(mk(0,32'h0,  0,0,32'h0,  32'h0,       32'h0,       0, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    // Single fetch, ready two cycles after grant.
    vecs.push_back(mk(1,32'h40, 0,0,32'h0,  32'h0,       32'h0,       0, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(1,32'h40, 0,0,32'h0,  32'h0,       32'hAAAA,    0, 0,0,1,0,32'h40, 32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(1,32'h40, 0,0,32'h0,  32'h0,       32'hAAAA,    0, 0,0,1,0,32'h40, 32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(1,32'h40, 0,0,32'h0,  32'h0,       32'h21080001,1, 1,0,1,0,32'h40, 32'h0,       32'h21080001,32'h0));
    vecs.push_back(mk(0,32'h0,  0,0,32'h0,  32'h0,       32'hFFFFFFFF,1, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    // Priority: data first, bubble, then the held fetch.
    vecs.push_back(mk(1,32'h44, 1,0,32'h80, 32'h0,       32'h11111111,1, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(1,32'h44, 1,0,32'h80, 32'h0,       32'h11111111,1, 0,1,1,0,32'h80, 32'h0,       32'h0,       32'h11111111));
    vecs.push_back(mk(1,32'h44, 0,0,32'h80, 32'h0,       32'h22222222,1, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(1,32'h44, 0,0,32'h80, 32'h0,       32'h22222222,1, 1,0,1,0,32'h44, 32'h0,       32'h22222222,32'h0));
    vecs.push_back(mk(0,32'h0,  0,0,32'h0,  32'h0,       32'h0,       0, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    // Write, then REN+WEN together still counts as a write.
    vecs.push_back(mk(0,32'h0,  0,1,32'h100,32'hDEADBEEF,32'h0,       0, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(0,32'h0,  0,1,32'h100,32'hDEADBEEF,32'h0,       0, 0,0,0,1,32'h100,32'hDEADBEEF,32'h0,       32'h0));
    vecs.push_back(mk(0,32'h0,  0,1,32'h100,32'hDEADBEEF,32'h33333333,1, 0,1,0,1,32'h100,32'hDEADBEEF,32'h0,       32'h33333333));
    vecs.push_back(mk(0,32'h0,  1,1,32'h104,32'h12345678,32'h0,       0, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(0,32'h0,  1,1,32'h104,32'h12345678,32'h0,       1, 0,1,0,1,32'h104,32'h12345678,32'h0,       32'h0));
    vecs.push_back(mk(0,32'h0,  0,0,32'h0,  32'h0,       32'h0,       0, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    // Fetch withdrawal before ready.
    vecs.push_back(mk(1,32'h200,0,0,32'h0,  32'h0,       32'h0,       0, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(1,32'h200,0,0,32'h0,  32'h0,       32'h0,       0, 0,0,1,0,32'h200,32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(0,32'h200,0,0,32'h0,  32'h0,       32'h0,       0, 0,0,0,0,32'h200,32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(0,32'h200,0,0,32'h0,  32'h0,       32'h44444444,1, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    // Data withdrawal in the same cycle the RAM reports ready.
    vecs.push_back(mk(0,32'h0,  1,0,32'h500,32'h0,       32'h0,       0, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(0,32'h0,  1,0,32'h500,32'h0,       32'h0,       0, 0,0,1,0,32'h500,32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(0,32'h0,  0,0,32'h500,32'h0,       32'h77777777,1, 0,0,0,0,32'h500,32'h0,       32'h0,       32'h0));
    vecs.push_back(mk(0,32'h0,  0,0,32'h0,  32'h0,       32'h77777777,1, 0,0,0,0,32'h0,  32'h0,       32'h0,       32'h0));

    // Reset state with live inputs asserted.
    nRST = 1'b0;
    apply_stimulus(mk(1,32'h40,1,1,32'h80,32'hFFFF,32'hFFFF,1, 0,0,0,0,0,0,0,0));
    #2;
    check_output("reset", mk(0,0,0,0,0,0,0,0, 0,0,0,0,32'h0,32'h0,32'h0,32'h0));
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d", i), vecs[i]);
    end

    // Watchdog: four waiting cycles in DACC set the sticky error.
    @(negedge CLK);
    apply_stimulus(mk(0,0,1,0,32'h300,0,0,0, 0,0,0,0,0,0,0,0));
    @(posedge CLK);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      #1;
      check_sig($sformatf("to_wait%0d err", k), 32'(timeout_err), 32'(k >= 4));
      check_sig($sformatf("to_wait%0d ramREN", k), 32'(ramREN), 32'd1);
    end
    ram_ready = 1'b1;
    ramload   = 32'h55AA55AA;
    #1;
    check_sig("to_hit dhit", 32'(dhit), 32'd1);
    check_sig("to_hit dmemload", dmemload, 32'h55AA55AA);
    check_sig("to_hit err", 32'(timeout_err), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      apply_stimulus(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
      #1;
      check_sig($sformatf("to_sticky%0d err", k), 32'(timeout_err), 32'd1);
      check_sig($sformatf("to_sticky%0d dhit", k), 32'(dhit), 32'd0);
    end
    #1 nRST = 1'b0;
    #1;
    check_sig("to_reset err", 32'(timeout_err), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Asynchronous reset in the middle of a waiting write.
    @(negedge CLK);
    apply_stimulus(mk(0,0,0,1,32'h400,32'hCAFEF00D,0,0, 0,0,0,0,0,0,0,0));
    @(posedge CLK);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      #1;
      check_sig($sformatf("ar_pre%0d ramWEN", k), 32'(ramWEN), 32'd1);
      check_sig($sformatf("ar_pre%0d ramstore", k), ramstore, 32'hCAFEF00D);
    end
    #1 nRST = 1'b0;
    ram_ready = 1'b1;
    #1;
    check_sig("ar_low ramWEN", 32'(ramWEN), 32'd0);
    check_sig("ar_low ramREN", 32'(ramREN), 32'd0);
    check_sig("ar_low dhit", 32'(dhit), 32'd0);
    check_sig("ar_low ramaddr", ramaddr, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check_sig("ar_rel dhit", 32'(dhit), 32'd0);
    check_sig("ar_rel ramWEN", 32'(ramWEN), 32'd0);
    ram_ready = 1'b0;
    @(posedge CLK);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      #1;
      check_sig($sformatf("ar_post%0d ramWEN", k), 32'(ramWEN), 32'd1);
      check_sig($sformatf("ar_post%0d err", k), 32'(timeout_err), 32'd0);
    end
    ram_ready = 1'b1;
    #1;
    check_sig("ar_done dhit", 32'(dhit), 32'd1);
    @(negedge CLK);
    apply_stimulus(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder end of the datapath-to-cache request interface. Accepts instruction-fetch and data-memory requests from the datapath and serialises them onto a single-port RAM.
- Returns ihit/dhit completion pulses and load data to the datapath.
- Data requests take priority over instruction requests. A grant is held until the RAM completes or the requester withdraws.
- A watchdog flags RAM accesses that never complete.

Parameters:
- ADDR_W, 32, byte-address width on both sides
- DATA_W, 32, word width
- TIMEOUT, 255, maximum wait cycles per RAM access before the error flag sets (1..65535)

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- imemREN  in  1  instruction fetch request
- imemaddr  in  ADDR_W  fetch address
- imemload  out  DATA_W  fetched word
- ihit  out  1  fetch complete, one-cycle pulse
- dmemREN  in  1  data read request
- dmemWEN  in  1  data write request
- dmemaddr  in  ADDR_W  data address
- dmemstore  in  DATA_W  store data
- dmemload  out  DATA_W  loaded word
- dhit  out  1  data access complete, one-cycle pulse
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ram_ready  in  1  RAM access done this cycle
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (nRST low, asynchronous):
  - FSM goes to IDLE; wait counter clears to 0.
  - All outputs read 0: ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, imemload, dmemload, timeout_err.
- FSM states: IDLE, DACC, IACC.
- IDLE:
  - If dmemREN or dmemWEN is high, go to DACC.
  - Otherwise, if imemREN is high, go to IACC.
  - Otherwise, stay in IDLE.
  - No RAM strobes are driven in IDLE.
  - Minimum latency: request at cycle N, grant at N+1, earliest hit at N+1 if ram_ready is already high.
- DACC:
  - ramaddr = dmemaddr and ramstore = dmemstore, both combinational from the live inputs.
  - ramWEN = dmemWEN.
  - ramREN = dmemREN & ~dmemWEN. If REN and WEN are both high, the access is a write and no read is issued.
  - In a cycle with ram_ready high: dhit = 1 and dmemload = ramload (combinational pass-through); next state is IDLE.
- IACC:
  - ramaddr = imemaddr and ramREN = 1; ramWEN = 0.
  - In a cycle with ram_ready high: ihit = 1 and imemload = ramload; next state is IDLE.
- Withdrawal: if the granted request drops before ram_ready (e.g. datapath flush), return to IDLE next cycle with no hit. Strobes deassert in the same cycle the request drops.
- A pending instruction request is never served while any data request is high. The datapath holds imemREN, so a fetch proceeds after the data hit.
- Back-to-back: the return to IDLE costs one bubble cycle. ihit and dhit are never high in the same cycle.
- ram_ready high in IDLE is ignored.
- Hits are one cycle wide. After a hit the FSM sits in IDLE for at least one cycle, so a still-held request cannot produce a duplicate hit in the same cycle.
- Wait counter (16-bit):
  - Clears on entry to DACC or IACC.
  - Increments each cycle in DACC/IACC without ram_ready, saturating at 65535.
  - When the counter reaches TIMEOUT, timeout_err sets and stays set until reset. The access keeps waiting; it is not aborted.
- imemload and dmemload outside their hit cycle hold 0.
- Reset mid-access forces IDLE immediately and drops all strobes in the same cycle.

Test Plan:
- Single fetch: imemREN=1 with imemaddr=0x0000_0040, ram_ready 2 cycles after grant with ramload=0x2108_0001 -> ramREN=1 and ramaddr=0x40 during IACC; ihit pulses for 1 cycle with imemload=0x2108_0001; return to IDLE.
- Priority: imemREN=1 and dmemREN=1 (dmemaddr=0x80) asserted together, ram_ready=1 every cycle -> DACC first with dhit; dmemREN dropped after dhit; after the bubble, IACC and ihit; never both hits in one cycle.
- Write: dmemWEN=1, dmemaddr=0x100, dmemstore=0xDEAD_BEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dhit on ram_ready. Repeat with REN=WEN=1 -> still ramREN=0.
- Withdrawal: grant IACC, drop imemREN before ram_ready -> strobes low that cycle, IDLE next cycle, no ihit.
- Timeout: TIMEOUT=4, hold ram_ready=0 in DACC -> timeout_err rises after 4 waiting cycles and stays high after a later ram_ready/dhit; clears only on nRST.
- Async reset mid-DACC: pulse nRST low between clock edges -> ramREN/ramWEN/dhit low immediately; FSM in IDLE with counter 0 on release.
